// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default geometry and the load/store request-type constants.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } memState_e;

   localparam int DEF_ADDR_W      = 10;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_DEPTH       = 1024;
   localparam int DEF_WAIT_STATES = 2;

   // Wait counter is wide enough for 0..15 wait states
   localparam int CNT_W = 4;

   localparam logic MEM_LOAD  = 1'b0;
   localparam logic MEM_STORE = 1'b1;

endpackage

// File: rtl/data_mem_responder_if.sv
// Bus between the CPU (control FSM + datapath) and the data-memory responder.
// The CPU side is the master; the responder is the slave.
interface data_mem_responder_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              MemEn;
   logic              MemWen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              mem_ready;
   logic              addr_err;
   logic              busy;

   modport master (
      output MemEn, MemWen, addr, wdata,
      input  rdata, mem_ready, addr_err, busy
   );

   modport slave (
      input  MemEn, MemWen, addr, wdata,
      output rdata, mem_ready, addr_err, busy
   );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port synchronous word RAM: one write enable, registered read with
// read enable so the read word is held between loads. Contents are not reset.
module data_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write port and registered read port sharing one address
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one armed request in IDLE, waits the
// configured number of BUSY cycles, then performs the RAM access on the edge
// into RESP and raises mem_ready for exactly one cycle.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WAIT_STATES = DEF_WAIT_STATES
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);

   localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);

   memState_e         state_q, state_d;
   logic              arm_q, arm_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wen_q, wen_d;
   logic              err_q, err_d;
   logic              rdValid_q, rdValid_d;

   logic              accept;
   logic              goResp;
   logic [ADDR_W-1:0] reqAddr;
   logic [DATA_W-1:0] reqWdata;
   logic              reqWen;
   logic              reqInRange;
   logic              ramWe;
   logic              ramRe;
   logic [DATA_W-1:0] ramRdata;

   // With zero wait states the access happens on the accept edge itself, so
   // the request is taken straight from the bus while in IDLE
   assign accept     = (state_q == IDLE) && bus.MemEn && arm_q;
   assign reqAddr    = (state_q == IDLE) ? bus.addr   : addr_q;
   assign reqWdata   = (state_q == IDLE) ? bus.wdata  : wdata_q;
   assign reqWen     = (state_q == IDLE) ? bus.MemWen : wen_q;
   assign reqInRange = ({1'b0, reqAddr} < DEPTH_EXT);

   // Next-state, arm, counter and request-capture logic
   always_comb begin
      state_d   = state_q;
      arm_d     = arm_q | ~bus.MemEn;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wen_d     = wen_q;
      err_d     = err_q;
      rdValid_d = rdValid_q;
      goResp    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               arm_d   = 1'b0;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               wen_d   = bus.MemWen;
               cnt_d   = WAIT_INIT;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  goResp  = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               goResp  = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (goResp) begin
         err_d = ~reqInRange;
         if (reqWen == MEM_LOAD) begin
            rdValid_d = reqInRange;
         end
      end
   end

   // State and captured-request registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         arm_q     <= 1'b1;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wen_q     <= MEM_LOAD;
         err_q     <= 1'b0;
         rdValid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_q     <= arm_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wen_q     <= wen_d;
         err_q     <= err_d;
         rdValid_q <= rdValid_d;
      end
   end

   // Out-of-range stores are dropped; reset discards any pending access
   assign ramWe = goResp && (reqWen == MEM_STORE) && reqInRange && !reset;
   assign ramRe = goResp && (reqWen == MEM_LOAD) && reqInRange && !reset;

   data_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (ramWe),
      .re_i    (ramRe),
      .addr_i  (reqAddr[IDX_W-1:0]),
      .wdata_i (reqWdata),
      .rdata_o (ramRdata)
   );

   // The RAM read register holds the last in-range load; rdValid selects
   // zero after reset or after an out-of-range load
   assign bus.rdata     = rdValid_q ? ramRdata : '0;
   assign bus.mem_ready = (state_q == RESP);
   assign bus.addr_err  = (state_q == RESP) && err_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: two instances (WAIT_STATES=2/DEPTH=512
// and WAIT_STATES=0/DEPTH=1024), a hand-written vector table, multi-cycle
// corner-case sequences and a randomized phase against a behavioural model.
module tb_data_mem_responder;
   import mem_pkg::*;

   localparam int WS_A    = 2;
   localparam int DEPTH_A = 512;
   localparam int WS_B    = 0;
   localparam int DEPTH_B = 1024;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   data_mem_responder_if #(.ADDR_W(10), .DATA_W(32)) busA ();
   data_mem_responder_if #(.ADDR_W(10), .DATA_W(32)) busB ();

   data_mem_responder #(
      .ADDR_W(10), .DATA_W(32), .DEPTH(DEPTH_A), .WAIT_STATES(WS_A)
   ) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA.slave)
   );

   data_mem_responder #(
      .ADDR_W(10), .DATA_W(32), .DEPTH(DEPTH_B), .WAIT_STATES(WS_B)
   ) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB.slave)
   );

   typedef struct {
      int          which;
      logic        wen;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] expRd;
      logic        expErr;
   } txnVec_t;

   int nCompared = 0;
   int nFailed   = 0;

   // Behavioural model: memory keyed by which*4096+addr, last load result
   logic [31:0] modelMem [int];
   logic [31:0] modelRd [2];
   logic        modelRdKnown [2];
   int          waitsOf [2];
   int          depthOf [2];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic driveReq(input int which, input logic en, input logic wen,
                           input logic [9:0] a, input logic [31:0] d);
      if (which == 0) begin
         busA.MemEn = en; busA.MemWen = wen; busA.addr = a; busA.wdata = d;
      end else begin
         busB.MemEn = en; busB.MemWen = wen; busB.addr = a; busB.wdata = d;
      end
   endtask

   task automatic sampleOut(input int which, output logic rdy, output logic err,
                            output logic bsy, output logic [31:0] rd);
      if (which == 0) begin
         rdy = busA.mem_ready; err = busA.addr_err; bsy = busA.busy; rd = busA.rdata;
      end else begin
         rdy = busB.mem_ready; err = busB.addr_err; bsy = busB.busy; rd = busB.rdata;
      end
   endtask

   // Issues one request in the current cycle and follows it to its response;
   // bus inputs are scrambled while the responder is busy
   task automatic runTxn(input int which, input logic wen, input logic [9:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic err, output int busyCnt, output logic after);
      logic rdy, bsy;
      logic [31:0] r;
      logic e;
      lat = -1; rd = '0; err = 1'b0; busyCnt = 0; after = 1'b0;
      driveReq(which, 1'b1, wen, a, d);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         sampleOut(which, rdy, e, bsy, r);
         if (bsy) busyCnt++;
         if (rdy) begin
            lat = k; rd = r; err = e;
            driveReq(which, 1'b0, 1'b0, 10'h0, 32'h0);
            break;
         end
         driveReq(which, 1'($urandom), 1'($urandom), 10'($urandom), $urandom);
      end
      driveReq(which, 1'b0, 1'b0, 10'h0, 32'h0);
      @(negedge clk);
      sampleOut(which, rdy, e, bsy, r);
      after = rdy | bsy;
   endtask

   task automatic modelPredict(input int which, input logic wen, input logic [9:0] a,
                               output logic [31:0] expRd, output logic known,
                               output logic expErr);
      int key;
      logic inRange;
      key = which * 4096 + int'(a);
      inRange = int'(a) < depthOf[which];
      expErr = !inRange;
      if (wen) begin
         expRd = modelRd[which]; known = modelRdKnown[which];
      end else if (!inRange) begin
         expRd = 32'h0; known = 1'b1;
      end else if (modelMem.exists(key)) begin
         expRd = modelMem[key]; known = 1'b1;
      end else begin
         expRd = 32'h0; known = 1'b0;
      end
   endtask

   task automatic modelCommit(input int which, input logic wen, input logic [9:0] a,
                              input logic [31:0] d, input logic [31:0] expRd,
                              input logic known);
      if (wen) begin
         if (int'(a) < depthOf[which]) modelMem[which * 4096 + int'(a)] = d;
      end else begin
         modelRd[which] = expRd; modelRdKnown[which] = known;
      end
   endtask

   task automatic applyStimulus(input string name, input int which, input logic wen,
                                input logic [9:0] a, input logic [31:0] d,
                                input logic [31:0] expRd, input logic known,
                                input logic expErr);
      int lat, busyCnt;
      logic [31:0] rd;
      logic err, after;
      runTxn(which, wen, a, d, lat, rd, err, busyCnt, after);
      checkOutput($sformatf("%s latency", name), 32'(lat), 32'(waitsOf[which] + 1));
      checkOutput($sformatf("%s busyCycles", name), 32'(busyCnt), 32'(waitsOf[which] + 1));
      checkOutput($sformatf("%s idleAfter", name), {31'h0, after}, 32'h0);
      checkOutput($sformatf("%s addr_err", name), {31'h0, err}, {31'h0, expErr});
      if (known) checkOutput($sformatf("%s rdata", name), rd, expRd);
      modelCommit(which, wen, a, d, expRd, known);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkVal(name, act, exp);
   endtask

   task automatic modelTxn(input string name, input int which, input logic wen,
                           input logic [9:0] a, input logic [31:0] d);
      logic [31:0] expRd;
      logic known, expErr;
      modelPredict(which, wen, a, expRd, known, expErr);
      applyStimulus(name, which, wen, a, d, expRd, known, expErr);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      txnVec_t vecs [13];
      logic rdy, err, bsy;
      logic [31:0] rd;
      int pulses, firstIdx, secondIdx;
      logic [31:0] pulseRd;

      waitsOf[0] = WS_A; depthOf[0] = DEPTH_A;
      waitsOf[1] = WS_B; depthOf[1] = DEPTH_B;
      modelRd[0] = 32'h0; modelRd[1] = 32'h0;
      modelRdKnown[0] = 1'b1; modelRdKnown[1] = 1'b1;

      vecs[0]  = '{0, 1'b1, 10'h000, 32'h0BADF00D, 32'h00000000, 1'b0};
      vecs[1]  = '{0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[2]  = '{0, 1'b0, 10'h005, 32'h00000000, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{0, 1'b1, 10'h200, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
      vecs[4]  = '{0, 1'b0, 10'h200, 32'h00000000, 32'h00000000, 1'b1};
      vecs[5]  = '{0, 1'b0, 10'h000, 32'h00000000, 32'h0BADF00D, 1'b0};
      vecs[6]  = '{0, 1'b1, 10'h1FF, 32'h5A5A5A5A, 32'h0BADF00D, 1'b0};
      vecs[7]  = '{0, 1'b0, 10'h1FF, 32'h00000000, 32'h5A5A5A5A, 1'b0};
      vecs[8]  = '{0, 1'b0, 10'h3FF, 32'h00000000, 32'h00000000, 1'b1};
      vecs[9]  = '{1, 1'b1, 10'h010, 32'h12345678, 32'h00000000, 1'b0};
      vecs[10] = '{1, 1'b0, 10'h010, 32'h00000000, 32'h12345678, 1'b0};
      vecs[11] = '{1, 1'b1, 10'h3FF, 32'hCAFEF00D, 32'h12345678, 1'b0};
      vecs[12] = '{1, 1'b0, 10'h3FF, 32'h00000000, 32'hCAFEF00D, 1'b0};

      reset = 1'b1;
      driveReq(0, 1'b0, 1'b0, 10'h0, 32'h0);
      driveReq(1, 1'b0, 1'b0, 10'h0, 32'h0);
      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         sampleOut(w, rdy, err, bsy, rd);
         checkOutput($sformatf("reset%0d mem_ready", w), {31'h0, rdy}, 32'h0);
         checkOutput($sformatf("reset%0d addr_err", w), {31'h0, err}, 32'h0);
         checkOutput($sformatf("reset%0d busy", w), {31'h0, bsy}, 32'h0);
         checkOutput($sformatf("reset%0d rdata", w), rd, 32'h0);
      end
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] vector table");
      for (int i = 0; i < 13; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].which, vecs[i].wen, vecs[i].addr,
                       vecs[i].wdata, vecs[i].expRd, 1'b1, vecs[i].expErr);
      end

      $display("[TB] MemEn held high");
      pulses = 0; firstIdx = -1; secondIdx = -1; pulseRd = 32'h0;
      for (int i = 0; i < 18; i++) begin
         if (i > 0) @(negedge clk);
         sampleOut(0, rdy, err, bsy, rd);
         if (rdy) begin
            pulses++;
            if (firstIdx < 0) firstIdx = i; else begin secondIdx = i; pulseRd = rd; end
         end
         driveReq(0, (i < 8) || (i == 9), 1'b0, 10'h005, 32'h0);
      end
      checkOutput("held pulses", 32'(pulses), 32'd2);
      checkOutput("held firstPulse", 32'(firstIdx), 32'(WS_A + 1));
      checkOutput("held secondPulse", 32'(secondIdx), 32'(9 + WS_A + 1));
      checkOutput("held rdata", pulseRd, 32'hDEADBEEF);
      modelRd[0] = 32'hDEADBEEF; modelRdKnown[0] = 1'b1;

      $display("[TB] bus changes while busy");
      modelTxn("busyPre2", 0, 1'b1, 10'h002, 32'h22222222);
      driveReq(0, 1'b1, 1'b1, 10'h001, 32'h00000001);
      for (int i = 1; i <= WS_A + 1; i++) begin
         @(negedge clk);
         sampleOut(0, rdy, err, bsy, rd);
         if (i == WS_A + 1) checkOutput("busyStore mem_ready", {31'h0, rdy}, 32'h1);
         driveReq(0, 1'b1, 1'b1, 10'h002, 32'h00000099);
      end
      driveReq(0, 1'b0, 1'b0, 10'h0, 32'h0);
      @(negedge clk);
      modelMem[1] = 32'h00000001;
      applyStimulus("busyLoad1", 0, 1'b0, 10'h001, 32'h0, 32'h00000001, 1'b1, 1'b0);
      applyStimulus("busyLoad2", 0, 1'b0, 10'h002, 32'h0, 32'h22222222, 1'b1, 1'b0);

      $display("[TB] reset during busy store");
      modelTxn("rstPreStore", 0, 1'b1, 10'h003, 32'h33333333);
      modelTxn("rstPreLoad", 0, 1'b0, 10'h003, 32'h0);
      driveReq(0, 1'b1, 1'b1, 10'h003, 32'hAAAA5555);
      @(negedge clk);
      driveReq(0, 1'b0, 1'b0, 10'h0, 32'h0);
      sampleOut(0, rdy, err, bsy, rd);
      checkOutput("rstBusy busyBefore", {31'h0, bsy}, 32'h1);
      reset = 1'b1;
      @(negedge clk);
      sampleOut(0, rdy, err, bsy, rd);
      checkOutput("rstBusy busy", {31'h0, bsy}, 32'h0);
      checkOutput("rstBusy mem_ready", {31'h0, rdy}, 32'h0);
      checkOutput("rstBusy rdata", rd, 32'h0);
      reset = 1'b0;
      modelRd[0] = 32'h0; modelRd[1] = 32'h0;
      modelRdKnown[0] = 1'b1; modelRdKnown[1] = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         sampleOut(0, rdy, err, bsy, rd);
         if (rdy || bsy) pulses++;
      end
      checkOutput("rstBusy noResponse", 32'(pulses), 32'd0);
      modelTxn("rstLoad3", 0, 1'b0, 10'h003, 32'h0);

      $display("[TB] randomized phase");
      for (int w = 0; w < 2; w++) begin
         for (int a = 0; a < 8; a++) begin
            modelTxn($sformatf("init%0d_%0d", w, a), w, 1'b1, 10'(a), $urandom);
         end
      end
      for (int i = 0; i < 120; i++) begin
         int w;
         logic [9:0] a;
         w = int'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) a = 10'($urandom_range(0, 1023));
         else a = 10'($urandom_range(0, 7));
         modelTxn($sformatf("rand%0d", i), w, 1'($urandom), a, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
